// File: rtl/pixel_pack_writer_pkg.sv
// Shared types and width helpers for the pixel pack writer.
// Holds the FSM state encoding and the BRAM word / byte-enable width math.
package pixel_pack_writer_pkg;

    localparam int DEF_PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic int word_w(input int pix_w, input int beats);
        return 4 * pix_w * beats;
    endfunction

    function automatic int be_w(input int pix_w, input int beats);
        return word_w(pix_w, beats) / 8;
    endfunction

endpackage

// File: rtl/pixel_pack_writer_if.sv
// Control, pixel-input and BRAM-write bundle of the pixel pack writer.
// master: steer/control side plus BRAM sink; slave: the writer itself.
interface pixel_pack_writer_if
    import pixel_pack_writer_pkg::*;
#(
    parameter int PIX_W          = DEF_PIX_W,
    parameter int BEATS_PER_WORD = 2,
    parameter int ADDR_W         = 10,
    parameter int CNT_W          = 16
);
    localparam int WORD_W = word_w(PIX_W, BEATS_PER_WORD);
    localparam int BE_W   = be_w(PIX_W, BEATS_PER_WORD);

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_beats;
    logic              in_valid;
    logic [PIX_W-1:0]  in1;
    logic [PIX_W-1:0]  in2;
    logic [PIX_W-1:0]  in3;
    logic [PIX_W-1:0]  in4;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [WORD_W-1:0] bram_din;
    logic [BE_W-1:0]   bram_be;
    logic              busy;
    logic              complete;
    logic              overflow;

    modport master (
        output start, base_addr, num_beats,
        output in_valid, in1, in2, in3, in4,
        input  bram_we, bram_addr, bram_din, bram_be,
        input  busy, complete, overflow
    );

    modport slave (
        input  start, base_addr, num_beats,
        input  in_valid, in1, in2, in3, in4,
        output bram_we, bram_addr, bram_din, bram_be,
        output busy, complete, overflow
    );

endinterface

// File: rtl/pixel_lane_packer.sv
// Lane insert register: collects 4-pixel beats into one BRAM word.
// Ports: i_clear/i_load/i_lane/i_beat in; o_word, o_be, o_word_ins out.
module pixel_lane_packer
    import pixel_pack_writer_pkg::*;
#(
    parameter int PIX_W          = DEF_PIX_W,
    parameter int BEATS_PER_WORD = 2,
    parameter int LIW            = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic [LIW-1:0]       i_lane,
    input  logic [4*PIX_W-1:0]   i_beat,
    output logic [word_w(PIX_W, BEATS_PER_WORD)-1:0] o_word,
    output logic [be_w(PIX_W, BEATS_PER_WORD)-1:0]   o_be,
    output logic [word_w(PIX_W, BEATS_PER_WORD)-1:0] o_word_ins
);
    localparam int LANE_W = 4 * PIX_W;
    localparam int LANE_B = LANE_W / 8;
    localparam int WORD_W = word_w(PIX_W, BEATS_PER_WORD);
    localparam int BE_W   = be_w(PIX_W, BEATS_PER_WORD);

    logic [WORD_W-1:0] r_word;
    logic [BE_W-1:0]   r_be;
    logic [WORD_W-1:0] w_word_ins;
    logic [BE_W-1:0]   w_be_ins;

    always_comb begin
        w_word_ins = r_word;
        w_be_ins   = r_be;
        for (int l = 0; l < BEATS_PER_WORD; l++) begin
            if (i_lane == l[LIW-1:0]) begin
                w_word_ins[l*LANE_W +: LANE_W] = i_beat;
                w_be_ins[l*LANE_B +: LANE_B]   = '1;
            end
        end
    end

    // Clear wins over load: on the last lane the full word leaves
    // through o_word_ins in the same edge that empties the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_be   <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_be   <= '0;
        end else if (i_load) begin
            r_word <= w_word_ins;
            r_be   <= w_be_ins;
        end
    end

    assign o_word     = r_word;
    assign o_be       = r_be;
    assign o_word_ins = w_word_ins;

endmodule

// File: rtl/pixel_pack_writer.sv
// Packs 4-pixel beats into BRAM words, flushes partial words with BEs.
// Ports: CLK, rst (async high), bus (slave: control, pixels, BRAM, status).
module pixel_pack_writer
    import pixel_pack_writer_pkg::*;
#(
    parameter int PIX_W          = DEF_PIX_W,
    parameter int BEATS_PER_WORD = 2,
    parameter int ADDR_W         = 10,
    parameter int CNT_W          = 16
) (
    input  logic          CLK,
    input  logic          rst,
    pixel_pack_writer_if.slave bus
);
    localparam int WORD_W = word_w(PIX_W, BEATS_PER_WORD);
    localparam int BE_W   = be_w(PIX_W, BEATS_PER_WORD);
    localparam int LIW    = (BEATS_PER_WORD > 1) ?
                            $clog2(BEATS_PER_WORD) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_num;
    logic [LIW-1:0]    r_lane;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_din;
    logic [BE_W-1:0]   r_be;
    logic              r_ovf;

    logic              w_start_acc;
    logic              w_load;
    logic              w_wr_full;
    logic              w_wr_flush;
    logic              w_clear;
    logic              w_last_lane;
    logic              w_end;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [LIW-1:0]    w_lane_nxt;
    logic [4*PIX_W-1:0] w_beat;
    logic [WORD_W-1:0] w_word;
    logic [BE_W-1:0]   w_be;
    logic [WORD_W-1:0] w_word_ins;

    assign w_beat = {bus.in4, bus.in3, bus.in2, bus.in1};

    pixel_lane_packer #(
        .PIX_W          (PIX_W),
        .BEATS_PER_WORD (BEATS_PER_WORD),
        .LIW            (LIW)
    ) u_packer (
        .clk        (CLK),
        .rst        (rst),
        .i_clear    (w_clear),
        .i_load     (w_load),
        .i_lane     (r_lane),
        .i_beat     (w_beat),
        .o_word     (w_word),
        .o_be       (w_be),
        .o_word_ins (w_word_ins)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_load      = 1'b0;
        w_wr_full   = 1'b0;
        w_wr_flush  = 1'b0;
        w_last_lane = (r_lane == LIW'(BEATS_PER_WORD - 1));
        w_cnt_inc   = r_cnt + 1'b1;
        w_end       = (w_cnt_inc == r_num);
        w_lane_nxt  = w_last_lane ? '0 : r_lane + 1'b1;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = (bus.num_beats == '0) ?
                                  ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.in_valid) begin
                    w_load    = 1'b1;
                    w_wr_full = w_last_lane;
                    if (w_end)
                        w_state_nxt = w_last_lane ?
                                      ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_wr_flush  = 1'b1;
                w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_clear = w_start_acc | w_wr_full | w_wr_flush;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_num   <= '0;
            r_lane  <= '0;
            r_waddr <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_be    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            r_be <= '0;
            if (w_start_acc) begin
                r_waddr <= bus.base_addr;
                r_num   <= bus.num_beats;
                r_cnt   <= '0;
                r_lane  <= '0;
            end
            if (w_load) begin
                r_cnt  <= w_cnt_inc;
                r_lane <= w_lane_nxt;
            end
            if (w_wr_full) begin
                r_we    <= 1'b1;
                r_addr  <= r_waddr;
                r_din   <= w_word_ins;
                r_be    <= '1;
                r_waddr <= r_waddr + 1'b1;
            end else if (w_wr_flush) begin
                r_we    <= 1'b1;
                r_addr  <= r_waddr;
                r_din   <= w_word;
                r_be    <= w_be;
                r_waddr <= r_waddr + 1'b1;
            end
            if (w_start_acc)
                r_ovf <= 1'b0;
            else if (bus.in_valid && r_state != ST_RUN)
                r_ovf <= 1'b1;
        end
    end

    assign bus.bram_we   = r_we;
    assign bus.bram_addr = r_addr;
    assign bus.bram_din  = r_din;
    assign bus.bram_be   = r_be;
    assign bus.busy      = (r_state == ST_RUN) ||
                           (r_state == ST_FLUSH);
    assign bus.complete  = (r_state == ST_DONE);
    assign bus.overflow  = r_ovf;

endmodule
